// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter
//   This block arbitrates three requesters for one external buffer controller.
//   Round-robin selection picks one requester at a time.
//   Each granted transaction issues the following sequence to the controller:
//     1. a burst command cycle,
//     2. a read/write strobe setup cycle,
//     3. the data phase,
//     4. a single-cycle done pulse back to the requester.
//
// Ports
//   host_clk, rst_n        clock, asynchronous active-low reset
//   req/req_wr             per-requester request level and direction (1 = write)
//   req_addr               per-requester start address, slice i at [i*ADDR_W +: ADDR_W]
//   req_len_minus1         per-requester burst length minus 1, slice i at [i*5 +: 5]
//   wdata / wpop           per-requester write word and its one-hot pop strobe
//   rdata / rvalid         shared read word, one-hot valid per requester
//   done                   one-hot transaction-complete pulse
//   gnt_id                 granted requester, 3 when idle
//   mem_*                  buffer-controller command, data and status signals
module ext_mem_arbiter #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  host_clk,
    input  logic                  rst_n,
    input  logic [2:0]            req,
    input  logic [2:0]            req_wr,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [14:0]           req_len_minus1,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            wpop,
    output logic [DATA_W-1:0]     rdata,
    output logic [2:0]            rvalid,
    output logic [2:0]            done,
    output logic [1:0]            gnt_id,
    output logic                  mem_burst,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [4:0]            mem_len_minus1,
    output logic [DATA_W-1:0]     mem_d,
    input  logic [DATA_W-1:0]     mem_q,
    input  logic                  mem_valid,
    input  logic                  mem_full
);

    typedef enum logic [2:0] {
        IDLE,
        CMD1,
        CMD2,
        WDATA,
        RDATA,
        DONE
    } state_t;

    state_t     state;
    logic       armed;
    logic [1:0] last_grant;
    logic [1:0] winner;
    logic       wr_lat;
    logic [5:0] cnt;
    logic [5:0] len_words;
    logic [2:0] win_onehot;
    logic [1:0] cand;
    logic [1:0] pick;
    logic       pick_ok;
    logic       write_go;

    // Round-robin search starting one past the last completed grant.
    always_comb begin
        cand    = 2'd0;
        pick    = 2'd0;
        pick_ok = 1'b0;
        for (int unsigned k = 1; k <= 3; k++) begin
            cand = 2'((32'(last_grant) + k) % 32'd3);
            if (!pick_ok && req[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    assign win_onehot = 3'b001 << winner;
    assign len_words  = {1'b0, mem_len_minus1} + 6'd1;

    // The write data path reacts to mem_full in the same cycle.
    // This keeps the strobes out of the registered FSM outputs,
    // so a full FIFO never takes an extra word.
    assign write_go = (state == WDATA) && !mem_full;
    assign mem_wr   = write_go;
    assign wpop     = write_go ? win_onehot : 3'b000;
    assign mem_d    = write_go ? wdata[32'(winner)*DATA_W +: DATA_W] : '0;

    always_ff @(posedge host_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            armed          <= 1'b0;
            last_grant     <= 2'd2;
            winner         <= 2'd0;
            wr_lat         <= 1'b0;
            cnt            <= '0;
            gnt_id         <= 2'd3;
            mem_burst      <= 1'b0;
            mem_rd         <= 1'b0;
            mem_addr       <= '0;
            mem_len_minus1 <= '0;
            rdata          <= '0;
            rvalid         <= '0;
            done           <= '0;
        end else begin
            // armed holds off granting on the first edge after reset release.
            armed     <= 1'b1;
            mem_burst <= 1'b0;
            rvalid    <= '0;
            done      <= '0;
            case (state)
                IDLE: begin
                    if (armed && pick_ok && !mem_full) begin
                        winner         <= pick;
                        wr_lat         <= req_wr[pick];
                        mem_addr       <= req_addr[32'(pick)*ADDR_W +: ADDR_W];
                        mem_len_minus1 <= req_len_minus1[32'(pick)*5 +: 5];
                        gnt_id         <= pick;
                        mem_burst      <= 1'b1;
                        cnt            <= '0;
                        state          <= CMD1;
                    end
                end
                CMD1: begin
                    mem_rd <= !wr_lat;
                    state  <= CMD2;
                end
                CMD2: begin
                    if (wr_lat) begin
                        mem_rd <= 1'b0;
                        state  <= WDATA;
                    end else begin
                        mem_rd <= 1'b1;
                        state  <= RDATA;
                    end
                end
                WDATA: begin
                    if (!mem_full) begin
                        cnt <= cnt + 6'd1;
                        if (cnt == {1'b0, mem_len_minus1}) begin
                            done  <= win_onehot;
                            state <= DONE;
                        end
                    end
                end
                RDATA: begin
                    if (cnt == len_words) begin
                        // The last word's rvalid is out this cycle; wrap up.
                        mem_rd <= 1'b0;
                        done   <= win_onehot;
                        state  <= DONE;
                    end else if (mem_valid) begin
                        rdata  <= mem_q;
                        rvalid <= win_onehot;
                        cnt    <= cnt + 6'd1;
                        if (cnt == {1'b0, mem_len_minus1}) begin
                            mem_rd <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    last_grant     <= winner;
                    gnt_id         <= 2'd3;
                    mem_addr       <= '0;
                    mem_len_minus1 <= '0;
                    mem_rd         <= 1'b0;
                    cnt            <= '0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
